// File: rtl/vect_pkg.sv
// Shared types and helpers for the vector memory stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default lane geometry, FSM state enum, latched-op record,
// and a lane slice helper for LANES*N vector buses.
package vect_pkg;

  localparam int DEF_N     = 24;
  localparam int DEF_LANES = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } vmem_state_t;

  // Everything captured from the EX/MEM register when a vector access starts.
  typedef struct packed {
    logic                         isLoad;
    logic                         regWrite;
    logic [DEF_N-1:0]             base;
    logic [DEF_LANES*DEF_N-1:0]   storeData;
  } vmem_op_t;

  // Lane i of a vector bus: bits [i*N +: N].
  function automatic logic [DEF_N-1:0] lane(input logic [DEF_LANES*DEF_N-1:0] vec,
                                            input int unsigned i);
    return vec[i*DEF_N +: DEF_N];
  endfunction

endpackage

// File: rtl/vect_lane_buf.sv
// LANES x N register file collecting the words of a vector load.
// Latency: write visible on rdVec the cycle after the write edge.
// Backpressure: none; writes are accepted every cycle weBuf is high.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (clears all lanes)
//   clr          zero every lane (takes priority over a write)
//   we/idx/wData write wData into lane idx
//   rdVec        all lanes in parallel, lane i at [i*N +: N]
import vect_pkg::*;

module vect_lane_buf #(
  parameter int N     = DEF_N,
  parameter int LANES = DEF_LANES,
  parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 we,
  input  logic [LW-1:0]        idx,
  input  logic [N-1:0]         wData,
  output logic [LANES*N-1:0]   rdVec
);

  logic [LANES-1:0][N-1:0] regs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (clr) begin
      regs <= '0;
    end else if (we && (int'(idx) < LANES)) begin
      regs[idx] <= wData;
    end
  end

  assign rdVec = regs;

endmodule

// File: rtl/vect_mem_stage.sv
// Vector memory stage: serializes vector loads/stores one lane-word at a time.
// Latency: 1 cycle for non-memory ops; LANES*(W+1)+2 cycles for memory ops (W waits/lane).
// Backpressure: raises stall while a vector access is accepted or in flight; memory side
//   uses a request/ready handshake, request and address held until memReady.
//
// Ports:
//   inValid/memRead/memWrite/regWriteIn/aluResult/storeData  EX/MEM register contents
//   memAddr/memWData/memWe/memRe/memRData/memReady          single-word memory port
//   stall                                                   freeze EX/MEM and earlier
//   outValid/regWriteOut/result                             toward write-back
import vect_pkg::*;

module vect_mem_stage #(
  parameter int N     = DEF_N,
  parameter int LANES = DEF_LANES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inValid,
  input  logic                 memRead,
  input  logic                 memWrite,
  input  logic                 regWriteIn,
  input  logic [LANES*N-1:0]   aluResult,
  input  logic [LANES*N-1:0]   storeData,
  output logic [N-1:0]         memAddr,
  output logic [N-1:0]         memWData,
  output logic                 memWe,
  output logic                 memRe,
  input  logic [N-1:0]         memRData,
  input  logic                 memReady,
  output logic                 stall,
  output logic                 outValid,
  output logic                 regWriteOut,
  output logic [LANES*N-1:0]   result
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  vmem_state_t          state;
  vmem_state_t          stateNxt;
  vmem_op_t             opLat;
  logic [LW-1:0]        laneIdx;
  logic                 isMem;
  logic                 isLast;
  logic                 bufClr;
  logic                 bufWe;
  logic [LANES*N-1:0]   bufVec;

  assign isMem  = inValid & (memRead | memWrite);
  assign isLast = (laneIdx == LW'(LANES - 1));

  vect_lane_buf #(
    .N     (N),
    .LANES (LANES),
    .LW    (LW)
  ) u_laneBuf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bufClr),
    .we    (bufWe),
    .idx   (laneIdx),
    .wData (memRData),
    .rdVec (bufVec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  // Memory-port outputs are decoded from state so a reset drops them immediately.
  always_comb begin
    stateNxt = state;
    stall    = 1'b0;
    memRe    = 1'b0;
    memWe    = 1'b0;
    memAddr  = '0;
    memWData = '0;
    bufClr   = 1'b0;
    bufWe    = 1'b0;
    case (state)
      IDLE: begin
        if (isMem) begin
          stall    = 1'b1;
          bufClr   = 1'b1;
          stateNxt = ACCESS;
        end
      end
      ACCESS: begin
        stall    = 1'b1;
        memRe    = opLat.isLoad;
        memWe    = ~opLat.isLoad;
        // Address wraps modulo 2^N.
        memAddr  = opLat.base + N'(laneIdx);
        memWData = lane(opLat.storeData, 32'(laneIdx));
        if (memReady) begin
          bufWe = opLat.isLoad;
          if (isLast) begin
            stateNxt = DONE;
          end
        end
      end
      DONE: begin
        // EX/MEM still holds the finished op here; stall=0 lets the next one in.
        stateNxt = IDLE;
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opLat       <= '0;
      laneIdx     <= '0;
      outValid    <= 1'b0;
      regWriteOut <= 1'b0;
      result      <= '0;
    end else begin
      outValid <= 1'b0;
      case (state)
        IDLE: begin
          if (isMem) begin
            // Both memRead and memWrite set is treated as a load.
            opLat <= '{isLoad:    memRead,
                       regWrite:  regWriteIn,
                       base:      aluResult[N-1:0],
                       storeData: storeData};
            laneIdx <= '0;
          end else begin
            result      <= aluResult;
            regWriteOut <= regWriteIn;
            outValid    <= inValid;
          end
        end
        ACCESS: begin
          // Counter parks on the last lane rather than wrapping.
          if (memReady && !isLast) begin
            laneIdx <= laneIdx + LW'(1);
          end
        end
        DONE: begin
          outValid <= 1'b1;
          if (opLat.isLoad) begin
            result      <= bufVec;
            regWriteOut <= opLat.regWrite;
          end else begin
            regWriteOut <= 1'b0;
          end
        end
        default: begin
          outValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vect_mem_stage.sv
module tb_vect_mem_stage;

  localparam int N  = 24;
  localparam int L  = 6;
  localparam int VW = L * N;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            inValid, memRead, memWrite, regWriteIn;
  logic [VW-1:0]   aluResult, storeData;
  logic [N-1:0]    memAddr, memWData, memRData;
  logic            memWe, memRe, memReady;
  logic            stall, outValid, regWriteOut;
  logic [VW-1:0]   result;

  int              passCnt = 0;
  int              failCnt = 0;
  int              chkCnt  = 0;

  // Memory model: content f(a) = 2a ^ salt, configurable wait count per word.
  logic [N-1:0]    salt = '0;
  int              waitCfg = 0;
  int              waitCnt = 0;
  logic            spurious = 1'b0;
  logic [N-1:0]    smem [0:63];
  logic [VW-1:0]   lastIdleAlu;

  always #5 clk = ~clk;

  vect_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .memRead(memRead), .memWrite(memWrite),
    .regWriteIn(regWriteIn), .aluResult(aluResult), .storeData(storeData),
    .memAddr(memAddr), .memWData(memWData), .memWe(memWe), .memRe(memRe),
    .memRData(memRData), .memReady(memReady), .stall(stall), .outValid(outValid),
    .regWriteOut(regWriteOut), .result(result)
  );

  function automatic logic [N-1:0] memFn(input logic [N-1:0] a);
    return {a[N-2:0], 1'b0} ^ salt;
  endfunction

  assign memRData = memFn(memAddr);
  assign memReady = (memRe | memWe) ? (waitCnt == waitCfg) : spurious;

  always @(posedge clk) begin
    if (!(memRe | memWe) || memReady) waitCnt <= 0;
    else                              waitCnt <= waitCnt + 1;
    if (memWe && memReady) smem[memAddr[5:0]] <= memWData;
  end

  function automatic logic [VW-1:0] randVec();
    logic [VW-1:0] v;
    for (int i = 0; i < L; i++) v[i*N +: N] = N'($urandom);
    return v;
  endfunction

  task automatic chkB(input string tag, input logic obs, input logic exp);
    chkCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkW(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    chkCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Non-memory op (or bubble): visible exactly one cycle later, never stalls.
  task automatic aluOp(input logic [VW-1:0] v, input bit vld, input bit rw);
    step();
    inValid = vld; memRead = 1'b0; memWrite = 1'b0; regWriteIn = rw; aluResult = v;
    #1 chkB("aluStall", stall, 1'b0);
    step();
    inValid = 1'b0; lastIdleAlu = v;
    #1;
    chkB("aluOutValid", outValid, vld);
    chkW("aluResult", result, v);
    chkB("aluRegWrite", regWriteOut, rw);
    chkB("aluStall2", stall, 1'b0);
    step();
    #1 chkB("aluOutOnce", outValid, 1'b0);
  endtask

  // Vector load/store: expected addresses, timing and result follow from the
  // per-lane serialization rule (W+1 cycles per lane, DONE, then output).
  task automatic memOp(input bit ld, input logic [N-1:0] base, input int w,
                       input bit rw, input bit followAlu, input logic [VW-1:0] sd);
    logic [VW-1:0] alu, expRes, nxt;
    logic [N-1:0]  a;
    int            acc, k;
    acc = L * (w + 1);
    alu = randVec();
    alu[N-1:0] = base;
    if (ld) for (int i = 0; i < L; i++) expRes[i*N +: N] = memFn(base + N'(i));
    else    expRes = lastIdleAlu;
    waitCfg = w;

    step();
    inValid = 1'b1; memRead = ld;
    memWrite = ld ? 1'($urandom_range(0, 1)) : 1'b1;
    regWriteIn = rw; aluResult = alu; storeData = sd;
    #1 chkB("acceptStall", stall, 1'b1);

    for (int c = 1; c <= acc; c++) begin
      step();
      #1;
      k = (c - 1) / (w + 1);
      a = base + N'(k);
      chkB("accStall", stall, 1'b1);
      chkW("accAddr", VW'(memAddr), VW'(a));
      chkB("accRe", memRe, ld);
      chkB("accWe", memWe, !ld);
      chkB("accNoOut", outValid, 1'b0);
      if (!ld) chkW("accWData", VW'(memWData), VW'(sd[k*N +: N]));
    end

    step();
    #1;
    chkB("doneStall", stall, 1'b0);
    chkB("doneRe", memRe, 1'b0);
    chkB("doneWe", memWe, 1'b0);
    chkB("doneNoOut", outValid, 1'b0);

    step();
    nxt = randVec();
    inValid = followAlu; memRead = 1'b0; memWrite = 1'b0; regWriteIn = followAlu;
    aluResult = nxt; lastIdleAlu = nxt;
    #1;
    chkB("memOutValid", outValid, 1'b1);
    chkW("memResult", result, expRes);
    chkB("memRegWrite", regWriteOut, ld ? rw : 1'b0);
    chkB("memNoReaccept", stall, 1'b0);

    step();
    inValid = 1'b0; regWriteIn = 1'b0;
    #1;
    chkB("followOut", outValid, followAlu);
    if (followAlu) chkW("followResult", result, nxt);

    step();
    #1 chkB("followOnce", outValid, 1'b0);

    if (!ld) for (int i = 0; i < L; i++) begin
      a = base + N'(i);
      chkW("storeMem", VW'(smem[a[5:0]]), VW'(sd[i*N +: N]));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] v;
    logic [N-1:0]  b;

    rst_n = 1'b0; inValid = 1'b0; memRead = 1'b0; memWrite = 1'b0; regWriteIn = 1'b0;
    aluResult = '0; storeData = '0; lastIdleAlu = '0;
    repeat (3) @(posedge clk);
    #1;
    chkB("rstWe", memWe, 1'b0);
    chkB("rstRe", memRe, 1'b0);
    chkB("rstStall", stall, 1'b0);
    chkB("rstOut", outValid, 1'b0);
    chkB("rstRegW", regWriteOut, 1'b0);
    chkW("rstResult", result, '0);
    chkW("rstAddr", VW'(memAddr), '0);
    chkW("rstWData", VW'(memWData), '0);
    @(negedge clk) rst_n = 1'b1;

    // Non-memory op with lanes 1..6.
    for (int i = 0; i < L; i++) v[i*N +: N] = N'(i + 1);
    aluOp(v, 1'b1, 1'b1);

    // Zero-wait load from 0x10, memory holds 2a.
    memOp(1'b1, 24'h000010, 0, 1'b1, 1'b0, randVec());

    // Store with two waits per lane, data 0xA..0xF.
    for (int i = 0; i < L; i++) v[i*N +: N] = N'(10 + i);
    memOp(1'b0, N'($urandom), 2, 1'b1, 1'b0, v);

    // Address wrap.
    memOp(1'b1, 24'hFFFFFE, 1, 1'b1, 1'b0, randVec());

    // Load followed by an ALU op waiting behind the stall.
    memOp(1'b1, N'($urandom), 0, 1'b1, 1'b1, randVec());

    // Reset in the middle of an access (lane 3).
    waitCfg = 0;
    b = N'($urandom);
    step();
    inValid = 1'b1; memRead = 1'b1; memWrite = 1'b0; regWriteIn = 1'b1;
    aluResult = randVec(); aluResult[N-1:0] = b;
    for (int c = 1; c <= 4; c++) step();
    #1 chkW("abortAddr", VW'(memAddr), VW'(b + 24'd3));
    inValid = 1'b0;
    #1;
    chkB("abortPreStall", stall, 1'b1);
    chkB("abortPreRe", memRe, 1'b1);
    rst_n = 1'b0;
    #1;
    chkB("abortRe", memRe, 1'b0);
    chkB("abortWe", memWe, 1'b0);
    chkB("abortStall", stall, 1'b0);
    chkB("abortOut", outValid, 1'b0);
    aluResult = '0; lastIdleAlu = '0;
    step();
    step();
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      #1;
      chkB("postRstOut", outValid, 1'b0);
      chkB("postRstRe", memRe, 1'b0);
      chkB("postRstStall", stall, 1'b0);
    end

    // Randomized mix; memReady is also asserted when no request is pending.
    salt = N'($urandom);
    spurious = 1'b1;
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 2) == 0)
        aluOp(randVec(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        memOp(1'($urandom_range(0, 1)), N'($urandom), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), randVec());
    end

    $display("%0d/%0d checks passed", passCnt, chkCnt);
    $finish;
  end

endmodule
